// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: control codes, ALUOp values,
// funct3 values, FSM states and {N,Z,C,V} flag bit positions.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_ILL   = 2'b11;

   localparam logic [2:0] F3_ADDSUB = 3'b000;
   localparam logic [2:0] F3_SLT    = 3'b010;
   localparam logic [2:0] F3_OR     = 3'b110;
   localparam logic [2:0] F3_AND    = 3'b111;
   localparam logic [2:0] F3_BEQ    = 3'b000;
   localparam logic [2:0] F3_BNE    = 3'b001;
   localparam logic [2:0] F3_BLT    = 3'b100;
   localparam logic [2:0] F3_BGE    = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct -> {ALU control code, illegal} decoder.
// ALU_BRANCH_RESOLVE_EN restricts aluop 01 to the four supported branch funct3 values.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] ctrl,
   output logic       illegal
);

   always_comb begin
      ctrl    = ALU_ADD;
      illegal = 1'b0;
      case (aluop)
         ALUOP_ADD: ctrl = ALU_ADD;
         ALUOP_BR: begin
`ifdef ALU_BRANCH_RESOLVE_EN
            case (funct3)
               F3_BEQ, F3_BNE, F3_BLT, F3_BGE: ctrl = ALU_SUB;
               default:                        illegal = 1'b1;
            endcase
`else
            ctrl = ALU_SUB;
`endif
         end
         ALUOP_FUNCT: begin
            case (funct3)
               // Only R-type with bit 30 set subtracts; addi shares funct3 000.
               F3_ADDSUB: ctrl = ({op5, funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
               F3_SLT:    ctrl = ALU_SLT;
               F3_OR:     ctrl = ALU_OR;
               F3_AND:    ctrl = ALU_AND;
               default:   illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded request to an external ALU and returns a registered response.
// Optional branch resolution is enabled with ALU_BRANCH_RESOLVE_EN.
// Request/response handshakes: a transfer occurs on a rising edge where valid and
// ready are both high; rsp_* hold stable while rsp_valid is high and rsp_ready low.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_aluop,
   input  logic [2:0]        req_funct3,
   input  logic              req_funct7b5,
   input  logic              req_op5,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_neg,
   input  logic              alu_carry,
   input  logic              alu_ovf,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic [3:0]        rsp_flags,
   output logic              rsp_taken,
   output logic              rsp_illegal,
   output state_t            dbg_state
);

   state_t            state_q, state_d;
   logic [CTRL_W-1:0] dec_ctrl;
   logic              dec_ill;
   logic              ill_q;
   logic              taken_c;
`ifdef ALU_BRANCH_RESOLVE_EN
   logic [1:0]        aluop_q;
   logic [2:0]        f3_q;
`endif

   alu_ctrl_decode u_decode (
      .aluop    (req_aluop),
      .funct3   (req_funct3),
      .funct7b5 (req_funct7b5),
      .op5      (req_op5),
      .ctrl     (dec_ctrl),
      .illegal  (dec_ill)
   );

   assign req_ready = (state_q == ST_IDLE);
   assign dbg_state = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req_valid) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Branch outcome from the live ALU flags while operands sit on alu_* in EXEC.
   always_comb begin
      taken_c = 1'b0;
`ifdef ALU_BRANCH_RESOLVE_EN
      if (aluop_q == ALUOP_BR && !ill_q) begin
         case (f3_q)
            F3_BEQ:  taken_c = alu_zero;
            F3_BNE:  taken_c = !alu_zero;
            F3_BLT:  taken_c = alu_neg ^ alu_ovf;
            F3_BGE:  taken_c = !(alu_neg ^ alu_ovf);
            default: taken_c = 1'b0;
         endcase
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         alu_a       <= '0;
         alu_b       <= '0;
         alu_ctrl    <= '0;
         ill_q       <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_result  <= '0;
         rsp_flags   <= '0;
         rsp_taken   <= 1'b0;
         rsp_illegal <= 1'b0;
`ifdef ALU_BRANCH_RESOLVE_EN
         aluop_q     <= '0;
         f3_q        <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: if (req_valid) begin
               alu_a    <= req_a;
               alu_b    <= req_b;
               alu_ctrl <= dec_ctrl;
               ill_q    <= dec_ill;
`ifdef ALU_BRANCH_RESOLVE_EN
               aluop_q  <= req_aluop;
               f3_q     <= req_funct3;
`endif
            end
            ST_EXEC: begin
               rsp_result  <= alu_result;
               rsp_flags   <= {alu_neg, alu_zero, alu_carry, alu_ovf};
               rsp_taken   <= taken_c;
               rsp_illegal <= ill_q;
               rsp_valid   <= 1'b1;
            end
            ST_RESP: if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
